// File: rtl/b_dly_pkg.sv
// Shared types and helpers for the delay-line code controller and its vote unit.
package b_dly_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_EVAL
  } state_t;

  // Channel-index width; a single channel still needs a 1-bit select.
  function automatic int ch_w(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  function automatic int sel_lo(input int ch, input int sel_w);
    return ch * sel_w;
  endfunction

endpackage

// File: rtl/b_dly_vote.sv
// Phase-detector sampler: counts 2^AVG_W samples and majority-votes the ones seen.
module b_dly_vote #(
  parameter int AVG_W = 3
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_clr,
  input  logic i_en,
  input  logic i_pd,
  output logic o_last,
  output logic o_major
);

  localparam logic [AVG_W:0] HALF = (AVG_W + 1)'(1 << (AVG_W - 1));

  logic [AVG_W-1:0] cnt_q;
  logic [AVG_W:0]   ones_q;

  always_ff @(posedge i_clk) begin
    if (!i_rstn || i_clr) begin
      cnt_q  <= '0;
      ones_q <= '0;
    end else if (i_en) begin
      cnt_q  <= cnt_q + 1'b1;
      ones_q <= ones_q + (AVG_W + 1)'(i_pd);
    end
  end

  assign o_last  = i_en & (&cnt_q);
  assign o_major = (ones_q > HALF);

endmodule

// File: rtl/b_dly_line_cal.sv
// Multi-channel delay-code register bank with manual writes and a per-channel
// upward-sweep calibration that locks on the first code the detector calls late.
module b_dly_line_cal
  import b_dly_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int SEL_W  = 8,
  parameter int SETTLE = 4,
  parameter int AVG_W  = 3,
  localparam int CH_W  = ch_w(NCH)
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic                 i_mode,
  input  logic                 i_wr_vld,
  output logic                 o_wr_rdy,
  input  logic [CH_W-1:0]      i_wr_ch,
  input  logic [SEL_W-1:0]     i_wr_sel,
  input  logic                 i_cal_start,
  input  logic [CH_W-1:0]      i_cal_ch,
  input  logic [NCH-1:0]       i_pd,
  output logic [NCH*SEL_W-1:0] o_dly_sel,
  output logic                 o_busy,
  output logic                 o_cal_done,
  output logic                 o_cal_fail
);

  localparam int             CNT_W       = $clog2(SETTLE + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [CH_W:0]  NCH_L       = (CH_W + 1)'(NCH);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] code_q [NCH];
  logic [SEL_W-1:0] saved_q;
  logic [CH_W-1:0]  cal_ch_q;
  logic [CNT_W-1:0] settle_q;
  logic             done_q, fail_q;

  logic             code_we, start_acc, done_d, fail_d;
  logic [CH_W-1:0]  code_ch;
  logic [SEL_W-1:0] code_val, cur_code;
  logic             wr_fire, vote_last, vote_major;

  assign o_wr_rdy   = i_rstn & (state_q == ST_IDLE);
  assign o_busy     = i_rstn & (state_q != ST_IDLE);
  assign o_cal_done = done_q;
  assign o_cal_fail = fail_q;
  assign wr_fire    = i_wr_vld & o_wr_rdy;
  assign cur_code   = code_q[cal_ch_q];

  b_dly_vote #(.AVG_W(AVG_W)) u_vote (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_clr   (state_q == ST_SETTLE),
    .i_en    (state_q == ST_SAMPLE),
    .i_pd    (i_pd[cal_ch_q]),
    .o_last  (vote_last),
    .o_major (vote_major)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d   = state_q;
    code_we   = 1'b0;
    code_ch   = cal_ch_q;
    code_val  = '0;
    start_acc = 1'b0;
    done_d    = 1'b0;
    fail_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (wr_fire) begin
          code_we  = ({1'b0, i_wr_ch} < NCH_L);
          code_ch  = i_wr_ch;
          code_val = i_wr_sel;
        end else if (i_cal_start && i_mode && ({1'b0, i_cal_ch} < NCH_L)) begin
          start_acc = 1'b1;
          code_we   = 1'b1;
          code_ch   = i_cal_ch;
          state_d   = ST_SETTLE;
        end
      end
      ST_SETTLE: if (settle_q == SETTLE_LAST) state_d = ST_SAMPLE;
      ST_SAMPLE: if (vote_last) state_d = ST_EVAL;
      ST_EVAL: begin
        if (vote_major) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (cur_code == '1) begin
          code_we  = 1'b1;
          code_val = saved_q;
          fail_d   = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          code_we  = 1'b1;
          code_val = cur_code + 1'b1;
          state_d  = ST_SETTLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Losing calibration mode beats any EVAL decision made in the same cycle.
    if (state_q != ST_IDLE && !i_mode) begin
      state_d  = ST_IDLE;
      code_we  = 1'b1;
      code_ch  = cal_ch_q;
      code_val = saved_q;
      done_d   = 1'b0;
      fail_d   = 1'b1;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q  <= ST_IDLE;
      saved_q  <= '0;
      cal_ch_q <= '0;
      settle_q <= '0;
      done_q   <= 1'b0;
      fail_q   <= 1'b0;
      // NOTE: the code array is reset because o_dly_sel must read zero after reset.
      for (int k = 0; k < NCH; k++) code_q[k] <= '0;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      fail_q   <= fail_d;
      settle_q <= (state_q == ST_SETTLE) ? settle_q + 1'b1 : '0;
      if (start_acc) begin
        saved_q  <= code_q[i_cal_ch];
        cal_ch_q <= i_cal_ch;
      end
      if (code_we) code_q[code_ch] <= code_val;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_pack
    assign o_dly_sel[sel_lo(k, SEL_W) +: SEL_W] = code_q[k];
  end

endmodule

// File: tb/tb_b_dly_line_cal.sv
// Self-checking bench for b_dly_line_cal: cycle-level behavioural model plus directed scenarios.
module tb_b_dly_line_cal;

  localparam int STEP = 13;

  logic        clk = 1'b0;
  logic        rstn, mode, wr_vld, wr_rdy, cal_start, busy, cal_done, cal_fail;
  logic [1:0]  wr_ch, cal_ch;
  logic [7:0]  wr_sel;
  logic [3:0]  pd = '0;
  logic [31:0] dly_sel;

  int n_pass = 0;
  int n_total = 0;

  int pd_kind = 1;
  int thr = 37;
  int pd_phase = 0;

  b_dly_line_cal #(.NCH(4), .SEL_W(8), .SETTLE(4), .AVG_W(3)) dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_mode      (mode),
    .i_wr_vld    (wr_vld),
    .o_wr_rdy    (wr_rdy),
    .i_wr_ch     (wr_ch),
    .i_wr_sel    (wr_sel),
    .i_cal_start (cal_start),
    .i_cal_ch    (cal_ch),
    .i_pd        (pd),
    .o_dly_sel   (dly_sel),
    .o_busy      (busy),
    .o_cal_done  (cal_done),
    .o_cal_fail  (cal_fail)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Detector stimulus: derived from each channel's current code.
  always @(negedge clk) begin
    int c;
    pd_phase++;
    for (int k = 0; k < 4; k++) begin
      c = int'(dly_sel[k*8 +: 8]);
      case (pd_kind)
        0: pd[k] = 1'b0;
        1: pd[k] = (c >= thr);
        2: pd[k] = (c >= 22) ? 1'b1 : (c == 21) ? ((pd_phase % 8) < 5) :
                   (c == 20) ? ((pd_phase % 8) < 4) : 1'b0;
        default: pd[k] = (c >= thr) ? (($urandom % 8) != 0) : (($urandom % 8) == 0);
      endcase
    end
  end

  // Behavioural model: calibration tracked as elapsed cycles since start; each
  // code step is 4 settle + 8 sample + 1 decide cycles.
  int m_code [4];
  bit m_busy, m_done, m_fail;
  int m_ch, m_saved, m_el, m_ones, m_ph;

  always @(posedge clk) begin
    m_done = 0;
    m_fail = 0;
    if (!rstn) begin
      for (int k = 0; k < 4; k++) m_code[k] = 0;
      m_busy = 0;
    end else if (!m_busy) begin
      if (wr_vld) m_code[wr_ch] = int'(wr_sel);
      else if (cal_start && mode) begin
        m_busy = 1; m_ch = int'(cal_ch); m_saved = m_code[m_ch];
        m_code[m_ch] = 0; m_el = 0; m_ones = 0;
      end
    end else if (!mode) begin
      m_code[m_ch] = m_saved; m_fail = 1; m_busy = 0;
    end else begin
      m_ph = m_el % STEP;
      if (m_ph >= 4 && m_ph < 12) m_ones += int'(pd[m_ch]);
      if (m_ph == 12) begin
        if (m_ones > 4) begin
          m_done = 1; m_busy = 0;
        end else if (m_code[m_ch] == 255) begin
          m_code[m_ch] = m_saved; m_fail = 1; m_busy = 0;
        end else begin
          m_code[m_ch]++; m_ones = 0;
        end
      end
      m_el++;
    end
  end

  always @(posedge clk) begin
    logic [31:0] exp_sel;
    #1;
    for (int k = 0; k < 4; k++) exp_sel[k*8 +: 8] = 8'(m_code[k]);
    check("dly_sel", dly_sel, exp_sel);
    check("busy", busy, m_busy & rstn);
    check("wr_rdy", wr_rdy, !m_busy & rstn);
    check("cal_done", cal_done, m_done);
    check("cal_fail", cal_fail, m_fail);
  end

  task automatic write_code(input int ch, input int val);
    @(negedge clk);
    wr_vld = 1'b1; wr_ch = 2'(ch); wr_sel = 8'(val);
    @(negedge clk);
    wr_vld = 1'b0;
  endtask

  task automatic run_cal(input int ch, input int limit, output int cyc,
                         output bit got_done, output bit got_fail);
    @(negedge clk);
    cal_start = 1'b1; cal_ch = 2'(ch);
    @(posedge clk);
    @(negedge clk);
    cal_start = 1'b0;
    cyc = 0; got_done = 0; got_fail = 0;
    while (cyc < limit && !got_done && !got_fail) begin
      @(posedge clk);
      #2;
      cyc++;
      got_done = cal_done;
      got_fail = cal_fail;
    end
    check("cal_end_seen", 64'(got_done | got_fail), 1);
  endtask

  initial begin
    int cyc;
    bit gd, gf;
    rstn = 1'b0; mode = 1'b1; wr_vld = 1'b0; wr_ch = '0; wr_sel = '0;
    cal_start = 1'b0; cal_ch = '0;
    repeat (3) @(negedge clk);
    check("rdy_in_reset", wr_rdy, 0);
    check("sel_in_reset", dly_sel, 0);
    rstn = 1'b1;
    @(negedge clk);
    check("rdy_after_reset", wr_rdy, 1);

    write_code(2, 8'h5A);
    check("write_ch2", dly_sel, 32'h005A_0000);
    write_code(0, 8'h11);
    write_code(3, 8'h77);

    // Clean threshold at 37: lock after 38 steps.
    pd_kind = 1; thr = 37;
    run_cal(1, 600, cyc, gd, gf);
    check("lock_done", gd, 1);
    check("lock_cycles", cyc, 38 * STEP);
    check("lock_codes", dly_sel, 32'h775A_2511);
    check("lock_busy_low", busy, 0);

    // 4/8 at code 20 is not a majority; 5/8 at code 21 is.
    pd_kind = 2;
    run_cal(1, 400, cyc, gd, gf);
    check("major_done", gd, 1);
    check("major_cycles", cyc, 22 * STEP);
    check("major_code", dly_sel[15:8], 8'd21);

    // Full sweep without lock restores the previous code.
    write_code(3, 8'h10);
    pd_kind = 0;
    run_cal(3, 4000, cyc, gd, gf);
    check("sweep_fail", gf, 1);
    check("sweep_cycles", cyc, 256 * STEP);
    check("sweep_restore", dly_sel, 32'h105A_1511);

    // Write attempt while busy is refused.
    @(negedge clk);
    cal_start = 1'b1; cal_ch = 2'd2;
    @(negedge clk);
    cal_start = 1'b0;
    wr_vld = 1'b1; wr_ch = 2'd2; wr_sel = 8'hEE;
    repeat (3) @(negedge clk);
    check("busy_rdy_low", wr_rdy, 0);
    check("busy_no_write", dly_sel[23:16], 8'h00);
    wr_vld = 1'b0; mode = 1'b0;
    @(negedge clk);
    mode = 1'b1;
    check("busy_abort_restore", dly_sel[23:16], 8'h5A);

    // Simultaneous write and start: write wins.
    @(negedge clk);
    wr_vld = 1'b1; wr_ch = 2'd1; wr_sel = 8'h42; cal_start = 1'b1; cal_ch = 2'd1;
    @(negedge clk);
    wr_vld = 1'b0; cal_start = 1'b0;
    check("conflict_busy", busy, 0);
    check("conflict_write", dly_sel[15:8], 8'h42);

    // Start with calibration disabled is ignored.
    mode = 1'b0;
    @(negedge clk);
    cal_start = 1'b1; cal_ch = 2'd1;
    @(negedge clk);
    cal_start = 1'b0;
    check("mode0_busy", busy, 0);
    mode = 1'b1;

    // Mode drop at code 5.
    write_code(0, 8'h33);
    @(negedge clk);
    cal_start = 1'b1; cal_ch = 2'd0;
    @(negedge clk);
    cal_start = 1'b0;
    repeat (67) @(negedge clk);
    check("abort_at_code5", dly_sel[7:0], 8'd5);
    mode = 1'b0;
    @(negedge clk);
    mode = 1'b1;
    check("abort_fail", cal_fail, 1);
    check("abort_restore", dly_sel[7:0], 8'h33);
    @(negedge clk);
    check("abort_pulse_one", cal_fail, 0);

    // Reset mid-calibration discards everything.
    @(negedge clk);
    cal_start = 1'b1; cal_ch = 2'd0;
    @(negedge clk);
    cal_start = 1'b0;
    repeat (67) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check("rst_codes", dly_sel, 0);
    check("rst_no_fail", cal_fail, 0);
    check("rst_no_done", cal_done, 0);
    rstn = 1'b1;

    // Randomised traffic against the model.
    pd_kind = 3;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (i % 500 == 0) thr = int'($urandom % 31);
      wr_vld    = (($urandom % 4) == 0);
      wr_ch     = 2'($urandom % 4);
      wr_sel    = 8'($urandom);
      cal_start = (($urandom % 16) == 0);
      cal_ch    = 2'($urandom % 4);
      mode      = (($urandom % 300) != 0);
    end
    @(negedge clk);
    wr_vld = 1'b0; cal_start = 1'b0; mode = 1'b0;
    @(negedge clk);
    mode = 1'b1;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
